sha256_msg_schedule: RTL and testbench

Message-schedule expander that sits directly upstream of the SHA-256 compression pipeline. It accepts one padded 512-bit block as sixteen 32-bit words and iteratively expands it into the 64-word schedule W[0:63]. It presents W[0:63] as a registered, stable array that the compression stage consumes via its W input. A valid/ready handshake is used on both sides.

---
 rtl/sha256_msg_schedule_if.sv | 24 ++
 rtl/sha256_msg_schedule.sv | 103 ++++++++++
 tb/tb_sha256_msg_schedule.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_msg_schedule_if.sv
// sha256_msg_schedule_if: block-in / schedule-out handshake bundle for the SHA-256 message-schedule expander.
`default_nettype none

interface sha256_msg_schedule_if;
  logic                  in_valid;
  logic                  in_ready;
  logic [0:15][31:0]     block_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [0:63][31:0]     W;
  logic                  busy;

  modport slave (
    input  in_valid, block_in, out_ready,
    output in_ready, out_valid, W, busy
  );

  modport master (
    output in_valid, block_in, out_ready,
    input  in_ready, out_valid, W, busy
  );
endinterface

`default_nettype wire

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule: expands one 16-word SHA-256 block into W[0:63], UNROLL words per cycle.
`default_nettype none

module sha256_msg_schedule #(
  parameter int UNROLL = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  sha256_msg_schedule_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    HOLD   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [0:63][31:0] w_q, w_d, w_ext;
  logic [6:0]        t_q, t_d, t_next;
  logic              out_valid_q, out_valid_d;
  logic [5:0]        idx;

  function automatic logic [31:0] s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  assign t_next = t_q + 7'(UNROLL);

  // Words of one cycle chain through w_ext, so W[j-2] may come from this same cycle.
  always_comb begin
    w_ext = w_q;
    idx   = '0;
    for (int k = 0; k < UNROLL; k++) begin
      idx = t_q[5:0] + 6'(k);
      if (t_q < 7'd64) begin
        w_ext[idx] = s1(w_ext[idx - 6'd2]) + w_ext[idx - 6'd7]
                   + s0(w_ext[idx - 6'd15]) + w_ext[idx - 6'd16];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    t_d         = t_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          w_d     = {bus.block_in, {48{32'h0}}};
          t_d     = 7'd16;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        w_d = w_ext;
        t_d = t_next;
        if (t_next >= 7'd64) begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        t_d         = 7'd16;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      w_q         <= '0;
      t_q         <= 7'd16;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      t_q         <= t_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == EXPAND);
  assign bus.out_valid = out_valid_q;
  assign bus.W         = w_q;

endmodule

`default_nettype wire

// File: tb/tb_sha256_msg_schedule.sv
// tb_sha256_msg_schedule: checks UNROLL=1/2/4 expanders side by side against a behavioural schedule model.
`default_nettype none

module tb_sha256_msg_schedule;

  typedef logic [0:15][31:0] blk_t;
  typedef logic [0:63][31:0] sched_t;
  typedef struct {
    int          sel;
    int          idx;
    logic [31:0] exp_w;
  } kat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  blk_t block_in = '0;

  always #5 clk = ~clk;

  sha256_msg_schedule_if if1();
  sha256_msg_schedule_if if2();
  sha256_msg_schedule_if if4();

  assign if1.in_valid = in_valid;  assign if1.block_in = block_in;  assign if1.out_ready = out_ready;
  assign if2.in_valid = in_valid;  assign if2.block_in = block_in;  assign if2.out_ready = out_ready;
  assign if4.in_valid = in_valid;  assign if4.block_in = block_in;  assign if4.out_ready = out_ready;

  sched_t w_o [3];
  logic   ov  [3];
  logic   ir  [3];
  logic   bz  [3];

  assign w_o[0] = if1.W;  assign ov[0] = if1.out_valid;  assign ir[0] = if1.in_ready;  assign bz[0] = if1.busy;
  assign w_o[1] = if2.W;  assign ov[1] = if2.out_valid;  assign ir[1] = if2.in_ready;  assign bz[1] = if2.busy;
  assign w_o[2] = if4.W;  assign ov[2] = if4.out_valid;  assign ir[2] = if4.in_ready;  assign bz[2] = if4.busy;

  sha256_msg_schedule #(.UNROLL(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
  sha256_msg_schedule #(.UNROLL(2)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave));
  sha256_msg_schedule #(.UNROLL(4)) dut4 (.clk(clk), .reset(reset), .bus(if4.slave));

  int     checks = 0;
  int     failures = 0;
  int     un [3] = '{1, 2, 4};
  int     lat [3];
  sched_t snap [3];
  sched_t abc_s [3];
  sched_t zero_s [3];
  kat_t   kat [10];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic sched_t model(input blk_t b);
    logic [31:0] w [64];
    sched_t r;
    for (int i = 0; i < 16; i++) w[i] = b[i];
    for (int j = 16; j < 64; j++)
      w[j] = (rotr(w[j-2], 17) ^ rotr(w[j-2], 19) ^ (w[j-2] >> 10)) + w[j-7]
           + (rotr(w[j-15], 7) ^ rotr(w[j-15], 18) ^ (w[j-15] >> 3)) + w[j-16];
    for (int i = 0; i < 64; i++) r[i] = w[i];
    return r;
  endfunction

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  task automatic chk_sched(input string nm, input sched_t act, input sched_t exp_v);
    int first;
    checks++;
    if (act !== exp_v) begin
      failures++;
      first = -1;
      for (int i = 63; i >= 0; i--) if (act[i] !== exp_v[i]) first = i;
      $display("FAIL %s: W[%0d] got %h expected %h", nm, first, act[first], exp_v[first]);
    end
  endtask

  // Waits (bounded) after an accept edge; records per-instance latency and schedule.
  task automatic wait_done();
    for (int i = 0; i < 3; i++) lat[i] = -1;
    for (int c = 1; c <= 56; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++)
        if (ov[i] && lat[i] < 0) begin
          lat[i]  = c;
          snap[i] = w_o[i];
        end
    end
  endtask

  task automatic run_block(input blk_t b);
    @(negedge clk);
    block_in  = b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done();
  endtask

  task automatic check_run(input string nm, input blk_t b);
    sched_t ref_s;
    ref_s = model(b);
    for (int i = 0; i < 3; i++) begin
      chk32($sformatf("%s_lat_u%0d", nm, un[i]), lat[i], 48 / un[i]);
      chk_sched($sformatf("%s_sched_u%0d", nm, un[i]), snap[i], ref_s);
    end
  endtask

  task automatic check_idle_clear(input string nm);
    for (int i = 0; i < 3; i++) begin
      chk_sched($sformatf("%s_W_u%0d", nm, un[i]), w_o[i], '0);
      chk32($sformatf("%s_ov_u%0d", nm, un[i]), 32'(ov[i]), 32'd0);
      chk32($sformatf("%s_ir_u%0d", nm, un[i]), 32'(ir[i]), 32'd1);
      chk32($sformatf("%s_busy_u%0d", nm, un[i]), 32'(bz[i]), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    blk_t   abc, zero, rb, b1, b2;
    sched_t hs [3];
    int     bad [3];
    sched_t s;

    abc      = '0;
    abc[0]   = 32'h61626380;
    abc[15]  = 32'h00000018;
    zero     = '0;

    kat[0] = '{0, 0,  32'h61626380};
    kat[1] = '{0, 15, 32'h00000018};
    kat[2] = '{0, 16, 32'h61626380};
    kat[3] = '{0, 17, 32'h000F0000};
    kat[4] = '{0, 18, 32'h7DA86405};
    kat[5] = '{0, 63, 32'h12B1EDEB};
    kat[6] = '{1, 0,  32'h00000000};
    kat[7] = '{1, 16, 32'h00000000};
    kat[8] = '{1, 40, 32'h00000000};
    kat[9] = '{1, 63, 32'h00000000};

    // Power-on reset state
    #12;
    check_idle_clear("reset");
    @(negedge clk);
    reset = 1'b0;

    run_block(abc);
    check_run("abc", abc);
    for (int i = 0; i < 3; i++) abc_s[i] = snap[i];

    run_block(zero);
    check_run("zero", zero);
    for (int i = 0; i < 3; i++) zero_s[i] = snap[i];

    for (int v = 0; v < 10; v++)
      for (int i = 0; i < 3; i++) begin
        s = (kat[v].sel == 0) ? abc_s[i] : zero_s[i];
        chk32($sformatf("kat%0d_W%0d_u%0d", v, kat[v].idx, un[i]), s[kat[v].idx], kat[v].exp_w);
      end

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 16; k++) rb[k] = $urandom;
      run_block(rb);
      check_run($sformatf("rand%0d", r), rb);
    end

    // Backpressure: hold in HOLD, ignore a second in_valid, then release
    for (int k = 0; k < 16; k++) begin
      b1[k] = $urandom;
      b2[k] = $urandom;
    end
    @(negedge clk);
    block_in  = b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      hs[i]  = w_o[i];
      bad[i] = 0;
      chk32($sformatf("bp_ov_u%0d", un[i]), 32'(ov[i]), 32'd1);
      chk_sched($sformatf("bp_sched_u%0d", un[i]), hs[i], model(b1));
    end
    @(negedge clk);
    block_in = b2;
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++)
        if (!ov[i] || ir[i] || w_o[i] !== hs[i]) bad[i]++;
    end
    for (int i = 0; i < 3; i++)
      chk32($sformatf("bp_stable_cycles_bad_u%0d", un[i]), bad[i], 0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk32($sformatf("bp_release_ov_u%0d", un[i]), 32'(ov[i]), 32'd0);
      chk32($sformatf("bp_release_ir_u%0d", un[i]), 32'(ir[i]), 32'd1);
      chk_sched($sformatf("bp_idle_keepW_u%0d", un[i]), w_o[i], hs[i]);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk32($sformatf("bp_accept2_ir_u%0d", un[i]), 32'(ir[i]), 32'd0);
      chk32($sformatf("bp_accept2_busy_u%0d", un[i]), 32'(bz[i]), 32'd1);
    end
    wait_done();
    check_run("bp_second", b2);

    // Asynchronous reset while the UNROLL=1 instance sits at t=30
    @(negedge clk);
    block_in = abc;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk32("midexp_busy_u1", 32'(bz[0]), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_idle_clear("async_reset");
    #2;
    reset = 1'b0;
    @(posedge clk); #1;
    check_idle_clear("post_reset_idle");

    run_block(abc);
    check_run("abc_after_reset", abc);
    for (int i = 0; i < 3; i++)
      chk32($sformatf("abc_after_reset_W63_u%0d", un[i]), snap[i][63], 32'h12B1EDEB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
